// File: rtl/gpu_pkg.sv
// Shared display-path constants: scale modes, default timing, and RGB332 field positions.
package gpu_pkg;

  localparam logic [1:0] SCALE_1X = 2'd0;
  localparam logic [1:0] SCALE_2X = 2'd1;
  localparam logic [1:0] SCALE_4X = 2'd2;

  localparam int unsigned DEF_PIXEL_W  = 8;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_HSTART   = 159;
  localparam int unsigned DEF_VSTART   = 44;
  localparam int unsigned CNT_W        = 12;
  localparam int unsigned ERR_CNT_W    = 16;

  localparam int unsigned RGB332_R_MSB = 7;
  localparam int unsigned RGB332_R_LSB = 5;
  localparam int unsigned RGB332_G_MSB = 4;
  localparam int unsigned RGB332_G_LSB = 2;
  localparam int unsigned RGB332_B_MSB = 1;
  localparam int unsigned RGB332_B_LSB = 0;

  // Replication shift for a scale mode; the reserved encoding behaves as 2x.
  function automatic logic [1:0] scale_shift(input logic [1:0] mode);
    case (mode)
      SCALE_1X: return 2'd0;
      SCALE_4X: return 2'd2;
      default:  return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/pixel_line_buffer.sv
// One scaled source line: synchronous write, combinational read on a shared address.
module pixel_line_buffer #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned DEPTH   = 320,
  parameter int unsigned AW      = 9
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [PIXEL_W-1:0] wdata,
  output logic [PIXEL_W-1:0] rdata_c
);

  logic [PIXEL_W-1:0] mem_q [DEPTH];
  logic               in_range_c;

  always_comb begin
    in_range_c = (32'(addr) < DEPTH);
    rdata_c    = in_range_c ? mem_q[addr] : '0;
  end

  // Storage is deliberately not reset; every line is written before it is read.
  always_ff @(posedge clk) begin
    if (we && in_range_c) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/pixel_scaler.sv
// Integer pixel replicator: pulls source pixels from a show-ahead FIFO and expands them 1x/2x/4x.
module pixel_scaler
  import gpu_pkg::*;
#(
  parameter int unsigned PIXEL_W  = DEF_PIXEL_W,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned HSTART   = DEF_HSTART,
  parameter int unsigned VSTART   = DEF_VSTART,
  parameter int unsigned LB_DEPTH = H_ACTIVE / 2
) (
  input  logic               clkPixel,
  input  logic               reset,
  input  logic               blank,
  input  logic [11:0]        h_count,
  input  logic [11:0]        v_count,
  input  logic [1:0]         scale,
  input  logic [PIXEL_W-1:0] fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               blank_out,
  output logic               frame_start,
  output logic               underflow,
  output logic [15:0]        underflow_cnt,
  input  logic               clear_err
);

  localparam int unsigned LB_AW = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [CNT_W-1:0]     px_c, ln_c, src_x_c;
  logic [1:0]           shift_c;
  logic                 active_c, fetch_line_c, first_px_c, need_c, uf_event_c;
  logic                 lb_we_c;
  logic [LB_AW-1:0]     lb_addr_c;
  logic [PIXEL_W-1:0]   lb_rdata_c, src_c;

  logic [PIXEL_W-1:0]   pixel_out_d, pixel_out_q;
  logic                 blank_out_d, blank_out_q;
  logic                 frame_start_d, frame_start_q;
  logic                 underflow_d, underflow_q;
  logic [ERR_CNT_W-1:0] underflow_cnt_d, underflow_cnt_q;
  logic [PIXEL_W-1:0]   hold_d, hold_q;
  logic [1:0]           scale_d, scale_q;
  logic                 rst_hold_d, rst_hold_q;

  // Raster decode: position within the active window and replication phase.
  always_comb begin
    px_c         = h_count - CNT_W'(HSTART + 1);
    ln_c         = v_count - CNT_W'(VSTART + 1);
    active_c     = (h_count > CNT_W'(HSTART)) && (v_count > CNT_W'(VSTART)) &&
                   (px_c < CNT_W'(H_ACTIVE)) && (ln_c < CNT_W'(V_ACTIVE));
    shift_c      = scale_shift(scale_q);
    fetch_line_c = 1'b1;
    first_px_c   = 1'b1;
    case (shift_c)
      2'd0: begin
        fetch_line_c = 1'b1;
        first_px_c   = 1'b1;
      end
      2'd1: begin
        fetch_line_c = ~ln_c[0];
        first_px_c   = ~px_c[0];
      end
      default: begin
        fetch_line_c = (ln_c[1:0] == 2'b00);
        first_px_c   = (px_c[1:0] == 2'b00);
      end
    endcase
    src_x_c   = px_c >> shift_c;
    lb_addr_c = LB_AW'(src_x_c);
  end

  // Fetch decision and source pixel select; a line cut short by reset stays idle until the next line.
  always_comb begin
    need_c      = active_c && fetch_line_c && first_px_c && !rst_hold_q && !reset;
    fifo_rd_en  = need_c && !fifo_empty;
    uf_event_c  = need_c && fifo_empty;
    lb_we_c     = need_c && (shift_c != 2'd0);
    src_c       = hold_q;
    if (need_c) begin
      src_c = fifo_empty ? hold_q : fifo_data;
    end else if (!fetch_line_c && first_px_c) begin
      src_c = lb_rdata_c;
    end
  end

  pixel_line_buffer #(
    .PIXEL_W (PIXEL_W),
    .DEPTH   (LB_DEPTH),
    .AW      (LB_AW)
  ) u_line_buf (
    .clk     (clkPixel),
    .we      (lb_we_c),
    .addr    (lb_addr_c),
    .wdata   (src_c),
    .rdata_c (lb_rdata_c)
  );

  // Next-state for all registered outputs and internal state.
  always_comb begin
    frame_start_d   = (h_count == '0) && (v_count == '0);
    scale_d         = frame_start_d ? scale : scale_q;
    blank_out_d     = blank;
    pixel_out_d     = '0;
    hold_d          = hold_q;
    underflow_d     = underflow_q;
    underflow_cnt_d = underflow_cnt_q;
    rst_hold_d      = rst_hold_q;

    if (!blank && active_c) begin
      pixel_out_d = src_c;
    end
    if (active_c && first_px_c) begin
      hold_d = src_c;
    end
    if (h_count == '0) begin
      rst_hold_d = 1'b0;
    end
    // A clear in the same cycle as an underflow wins; that event is dropped.
    if (clear_err) begin
      underflow_d     = 1'b0;
      underflow_cnt_d = '0;
    end else if (uf_event_c) begin
      underflow_d     = 1'b1;
      if (underflow_cnt_q != {ERR_CNT_W{1'b1}}) begin
        underflow_cnt_d = underflow_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clkPixel) begin
    if (reset) begin
      pixel_out_q     <= '0;
      blank_out_q     <= 1'b1;
      frame_start_q   <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
      hold_q          <= '0;
      scale_q         <= SCALE_2X;
      rst_hold_q      <= 1'b1;
    end else begin
      pixel_out_q     <= pixel_out_d;
      blank_out_q     <= blank_out_d;
      frame_start_q   <= frame_start_d;
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
      hold_q          <= hold_d;
      scale_q         <= scale_d;
      rst_hold_q      <= rst_hold_d;
    end
  end

  always_comb begin
    pixel_out     = pixel_out_q;
    blank_out     = blank_out_q;
    frame_start   = frame_start_q;
    underflow     = underflow_q;
    underflow_cnt = underflow_cnt_q;
  end

endmodule

// File: tb/tb_pixel_scaler.sv
// Directed bench for pixel_scaler on a reduced 16x8 raster driven cycle by cycle.
module tb_pixel_scaler;

  localparam int H_A   = 16;
  localparam int V_A   = 8;
  localparam int HS    = 3;
  localparam int VS    = 1;
  localparam int H_TOT = 24;
  localparam int V_TOT = 12;

  logic        clk = 1'b0;
  logic        reset, blank, fifo_empty, clear_err;
  logic [11:0] h_count, v_count;
  logic [1:0]  scale;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en, blank_out, frame_start, underflow;
  logic [7:0]  pixel_out;
  logic [15:0] underflow_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int next_val, frame_pops, blank_pops, lbwe_cnt;
  int line_pops[V_TOT];
  logic last_pop;

  pixel_scaler #(
    .PIXEL_W (8), .H_ACTIVE (H_A), .V_ACTIVE (V_A),
    .HSTART (HS), .VSTART (VS), .LB_DEPTH (H_A / 2)
  ) dut (
    .clkPixel (clk), .reset (reset), .blank (blank),
    .h_count (h_count), .v_count (v_count), .scale (scale),
    .fifo_data (fifo_data), .fifo_empty (fifo_empty), .fifo_rd_en (fifo_rd_en),
    .pixel_out (pixel_out), .blank_out (blank_out), .frame_start (frame_start),
    .underflow (underflow), .underflow_cnt (underflow_cnt), .clear_err (clear_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_active(input int h, input int v);
    return (h > HS) && (v > VS) && (h - (HS + 1) < H_A) && (v - (VS + 1) < V_A);
  endfunction

  // Expected pixel: ramp of pops from 0 each frame; mode 3 is the starved line-0 pattern.
  function automatic logic [7:0] exp_pix(input int mode, input int px, input int ln);
    int val;
    if (mode == 3) begin
      if (px < 6)       val = px >> 1;
      else if (px < 10) val = 2;
      else              val = (px >> 1) - 2;
    end else begin
      val = (ln >> mode) * (H_A >> mode) + (px >> mode);
    end
    return 8'(val % 256);
  endfunction

  // One pixel clock: drive at negedge, sample pop before the edge, outputs after it.
  task automatic step(input int h, input int v, input logic starve, input logic rst, input logic clr);
    @(negedge clk);
    h_count    = 12'(h);
    v_count    = 12'(v);
    blank      = !in_active(h, v);
    reset      = rst;
    clear_err  = clr;
    fifo_data  = 8'(next_val);
    fifo_empty = starve;
    #1;
    last_pop = fifo_rd_en;
    if (dut.lb_we_c) lbwe_cnt++;
    @(posedge clk);
    #1;
    if (last_pop === 1'b1) begin
      next_val++;
      frame_pops++;
      if (in_active(h, v)) line_pops[v]++;
      else blank_pops++;
    end
  endtask

  task automatic run_frame(input int mode, input int st_v, input int st_lo, input int st_hi,
                           input int rst_v, input int rst_px, input int chg_v, input logic [1:0] chg_scale);
    next_val = 0; frame_pops = 0; blank_pops = 0; lbwe_cnt = 0;
    for (int i = 0; i < V_TOT; i++) line_pops[i] = 0;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        int   px, ln;
        logic st, rs;
        px = h - (HS + 1);
        ln = v - (VS + 1);
        if (v == chg_v && h == 0) scale = chg_scale;
        st = (v == st_v) && (px >= st_lo) && (px <= st_hi);
        rs = (v == rst_v) && (px == rst_px);
        step(h, v, st, rs, 1'b0);
        if (h == 0 && v == 0) check_eq("frame_start_pulse", 32'(frame_start), 32'd1);
        if (h == 1 && v == 0) check_eq("frame_start_low", 32'(frame_start), 32'd0);
        if (rs) begin
          check_eq("rd_en_in_reset", 32'(last_pop), 32'd0);
          check_eq("reset_pixel_out", 32'(pixel_out), 32'd0);
          check_eq("reset_blank_out", 32'(blank_out), 32'd1);
          check_eq("reset_uf_cnt", 32'(underflow_cnt), 32'd0);
          check_eq("reset_uf", 32'(underflow), 32'd0);
        end else begin
          check_eq($sformatf("blank_out v%0d h%0d", v, h), 32'(blank_out), 32'(!in_active(h, v)));
          if (!in_active(h, v))
            check_eq($sformatf("blank_pix v%0d h%0d", v, h), 32'(pixel_out), 32'd0);
          else if ((mode >= 0 && mode <= 2) || (mode == 3 && ln < 2))
            check_eq($sformatf("pix m%0d ln%0d px%0d", mode, ln, px), 32'(pixel_out), 32'(exp_pix(mode, px, ln)));
        end
      end
    end
    check_eq("blank_pops", 32'(blank_pops), 32'd0);
  endtask

  initial begin
    reset = 1'b1; clear_err = 1'b0; scale = 2'd0; fifo_empty = 1'b0; fifo_data = 8'h5a;
    h_count = 12'(HS + 1); v_count = 12'(VS + 1); blank = 1'b0;
    next_val = 0; frame_pops = 0; blank_pops = 0; lbwe_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pixel_out", 32'(pixel_out), 32'd0);
    check_eq("rst_blank_out", 32'(blank_out), 32'd1);
    check_eq("rst_frame_start", 32'(frame_start), 32'd0);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    check_eq("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);

    // Reset scale is 2x even with a 1x request pending: px1 must not pop, px2 must.
    step(0, VS + 1, 1'b0, 1'b0, 1'b0);
    step(HS + 2, VS + 1, 1'b0, 1'b0, 1'b0);
    check_eq("rst_scale_px1_no_pop", 32'(last_pop), 32'd0);
    step(HS + 3, VS + 1, 1'b0, 1'b0, 1'b0);
    check_eq("rst_scale_px2_pop", 32'(last_pop), 32'd1);

    scale = 2'd1;
    run_frame(1, -1, 0, -1, -1, -1, -1, 2'd0);
    check_eq("2x_frame_pops", 32'(frame_pops), 32'd32);
    check_eq("2x_even_line_pops", 32'(line_pops[VS + 1]), 32'd8);
    check_eq("2x_odd_line_pops", 32'(line_pops[VS + 2]), 32'd0);

    scale = 2'd0;
    run_frame(0, -1, 0, -1, -1, -1, -1, 2'd0);
    check_eq("1x_frame_pops", 32'(frame_pops), 32'd128);
    check_eq("1x_line_pops", 32'(line_pops[VS + 4]), 32'd16);
    check_eq("1x_lb_we", 32'(lbwe_cnt), 32'd0);

    // Request 4x mid-frame at ln4; this frame must stay 2x.
    scale = 2'd1;
    run_frame(1, -1, 0, -1, -1, -1, VS + 1 + 4, 2'd2);
    check_eq("chg_frame_pops", 32'(frame_pops), 32'd32);
    check_eq("chg_ln6_pops", 32'(line_pops[VS + 1 + 6]), 32'd8);

    run_frame(2, -1, 0, -1, -1, -1, -1, 2'd0);
    check_eq("4x_frame_pops", 32'(frame_pops), 32'd8);
    check_eq("4x_ln0_pops", 32'(line_pops[VS + 1]), 32'd4);
    check_eq("4x_ln1_pops", 32'(line_pops[VS + 2]), 32'd0);
    check_eq("4x_ln4_pops", 32'(line_pops[VS + 5]), 32'd4);

    scale = 2'd3;
    run_frame(1, -1, 0, -1, -1, -1, -1, 2'd0);
    check_eq("mode3_frame_pops", 32'(frame_pops), 32'd32);

    scale = 2'd1;
    run_frame(3, VS + 1, 6, 9, -1, -1, -1, 2'd0);
    check_eq("uf_ln0_pops", 32'(line_pops[VS + 1]), 32'd6);
    check_eq("uf_ln1_pops", 32'(line_pops[VS + 2]), 32'd0);
    check_eq("uf_flag", 32'(underflow), 32'd1);
    check_eq("uf_cnt", 32'(underflow_cnt), 32'd2);

    // Clear coinciding with a starved fetch: clear wins, then a lone starved fetch counts.
    step(HS + 1, VS + 1, 1'b1, 1'b0, 1'b1);
    check_eq("clr_flag", 32'(underflow), 32'd0);
    check_eq("clr_cnt", 32'(underflow_cnt), 32'd0);
    step(HS + 3, VS + 1, 1'b1, 1'b0, 1'b0);
    check_eq("post_clr_flag", 32'(underflow), 32'd1);
    check_eq("post_clr_cnt", 32'(underflow_cnt), 32'd1);

    run_frame(-1, -1, 0, -1, VS + 1, 10, -1, 2'd0);
    check_eq("rstmid_ln0_pops", 32'(line_pops[VS + 1]), 32'd5);
    check_eq("rstmid_ln1_pops", 32'(line_pops[VS + 2]), 32'd0);
    check_eq("rstmid_ln2_pops", 32'(line_pops[VS + 3]), 32'd8);
    check_eq("rstmid_frame_pops", 32'(frame_pops), 32'd29);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pixel_scaler.md
PIXEL_SCALER -- requirements
Module: pixel_scaler

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8, pixel width in bits (RGB332 at 8).
REQ-002 SHALL have parameter H_ACTIVE, default 640, display pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, display lines per frame.
REQ-004 SHALL have parameter HSTART, default 159; the first active pixel is at h_count == HSTART+1.
REQ-005 SHALL have parameter VSTART, default 44; the first active line is at v_count == VSTART+1.
REQ-006 SHALL have parameter LB_DEPTH, default H_ACTIVE/2, line buffer entries.
REQ-007 clkPixel  in  1  pixel clock; one clock only, all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 blank  in  1  timing-generator blanking.
REQ-010 h_count  in  12  line position, including blanking.
REQ-011 v_count  in  12  frame position, including blanking.
REQ-012 scale  in  2  requested mode: 0=1x, 1=2x, 2=4x, 3=treated as 2x.
REQ-013 fifo_data  in  PIXEL_W  source pixel at the FIFO head (show-ahead).
REQ-014 fifo_empty  in  1  FIFO empty.
REQ-015 fifo_rd_en  out  1  pops the head this cycle.
REQ-016 pixel_out  out  PIXEL_W  registered display pixel; zero when blanked.
REQ-017 blank_out  out  1  blank delayed by 1 cycle, aligned to pixel_out.
REQ-018 frame_start  out  1  one-cycle pulse, registered, for arbiter pointer reset.
REQ-019 underflow  out  1  sticky flag: at least one fetch hit an empty FIFO.
REQ-020 underflow_cnt  out  16  saturating count of underflowed fetches.
REQ-021 clear_err  in  1  zeroes underflow and underflow_cnt.

Function
REQ-022 Definitions: px = h_count-(HSTART+1); ln = v_count-(VSTART+1); active = h_count>HSTART, v_count>VSTART, px<H_ACTIVE, ln<V_ACTIVE. Widths: 10 bits minimum; 12-bit compare.
REQ-023 scale_reg SHALL load from scale only on the cycle h_count==0 and v_count==0; mid-frame scale changes SHALL take effect at the next frame.
REQ-024 frame_start SHALL be 1 on the cycle after h_count==0 and v_count==0, otherwise 0.
REQ-025 Shift k = 0/1/2 for 1x/2x/4x. src_x = px>>k. fetch_line = ln[k-1:0]==0; it is always true for 1x. first_px = px[k-1:0]==0; it is always true for 1x.
REQ-026 need = active & fetch_line & first_px.
REQ-027 fifo_rd_en = need & !fifo_empty (combinational).
REQ-028 On need with data: src = fifo_data.
REQ-029 On need without data: src = hold, and the underflow counters update.
REQ-030 On a non-fetch line with first_px: src = line_buf[src_x], a combinational read.
REQ-031 On a cycle that is not first_px: src = hold.
REQ-032 On need (k>0), line_buf[src_x] <= src, including the substituted value on underflow. In 1x mode the line buffer SHALL NOT be written.
REQ-033 hold <= src on active & first_px.
REQ-034 pixel_out <= blank ? 0 : (active ? src : 0). Latency is exactly 1 clkPixel from h_count/v_count.
REQ-035 underflow_cnt SHALL saturate at 16'hFFFF.
REQ-036 clear_err SHALL take priority over a simultaneous underflow event; that event is lost.
REQ-037 Boundary: the final fetch of a line occurs at px = H_ACTIVE-2^k. No reads occur outside active; the FIFO is never popped during blanking.
REQ-038 Boundary: the first active line of a frame is always a fetch line, so stale line buffer content is never displayed.

Reset
REQ-039 On reset: pixel_out=0, blank_out=1, frame_start=0, underflow=0, underflow_cnt=0, hold=0, scale_reg=1 (2x).
REQ-040 fifo_rd_en SHALL be 0 whenever reset is high.
REQ-041 Line buffer contents SHALL NOT be reset.
REQ-042 Reset mid-line SHALL cause no pops until the next active fetch.

Structure
REQ-043 A shared package (gpu_pkg) SHALL hold the scale-mode constants SCALE_1X/2X/4X, the default timing constants and RGB332 field positions.
REQ-044 One sub-module, pixel_line_buffer, SHALL provide LB_DEPTH x PIXEL_W storage with a synchronous write and a combinational read.

Verification
REQ-045 2x, FIFO preloaded with 0..255 ramp (mod 256), one frame: exactly 320 pops on each even line, 0 on odd lines, 76800 pops per frame; the odd line pixel_out sequence equals the even line; each value is held for 2 pixels.
REQ-046 4x: 160 pops per fetch line, 120 fetch lines, 19200 pops per frame; each value is repeated across a 4x4 block.
REQ-047 1x: 640 pops on every line, 307200 pops per frame; the line buffer write enable is never asserted.
REQ-048 2x, FIFO empty for px 100..103 on line 0: pixel_out repeats the px 98 value; underflow=1, underflow_cnt=2, and line 1 shows the same repeated value; clear_err then yields 0/0.
REQ-049 scale changed 1->2 at mid-frame ln=200: the pop pattern stays 2x until the frame ends; after the next frame_start it is 4x.
REQ-050 Reset asserted at px=300 of line 0: the next cycle has pixel_out=0, blank_out=1, no pops until the next fetch line; underflow_cnt=0.
